lbus_master: RTL and testbench
==============================

Name: lbus_master

Overview:
- Local-bus initiator that drives the Address/Read/Write/DataIn bus shared by the channel register slaves (config, particle-window and logic-analyzer registers).
- Takes one command at a time from a host-side valid/ready interface and runs a single read or write bus cycle.
- Captures the slaves' OR-ed read data and returns one response per command.
- Sits between the host command decoder and all channel slaves on the 50 MHz domain.

Parameters:
- STROBE_LEN, 2, Read/Write strobe width in clocks when ACK_EN=0; legal range 1..15.
- ACK_EN, 0, 1 = end the strobe on slave ack; 0 = fixed-width strobe.
- TIMEOUT, 16, maximum strobe cycles in ack mode before an error; legal range 2..255.

Ports:
- clk  in  1  single 50 MHz clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block is idle and can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  8  target register address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host accepts the response.
- rsp_rdata  out  32  read data; 0 for writes and for errors.
- rsp_err  out  1  ack timeout occurred.
- Address  out  8  bus address.
- DataOut  out  32  bus write data (drives the slaves' DataIn).
- DataIn  in  32  OR-ed slave read data (the slaves' DataOut).
- Read  out  1  read strobe.
- Write  out  1  write strobe.
- ack  in  1  OR-ed slave acknowledge; ignored when ACK_EN=0.
- err_count  out  8  saturating count of timeouts.

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1 once rst deasserts. State is IDLE.
- Reset asserted mid-transaction: strobes drop immediately (asynchronously), any pending response is discarded, err_count clears.
- State IDLE:
  - cmd_ready=1, Address=0, DataOut=0.
  - Acceptance occurs on an edge with cmd_valid&cmd_ready. The command is latched and the state moves to SETUP.
- State SETUP (1 cycle):
  - Address=cmd_addr; DataOut=cmd_wdata for writes, 0 for reads; strobes 0; cmd_ready=0.
- State STROBE:
  - Exactly one of Write or Read is 1 (Write if cmd_write, else Read). Read and Write are never 1 together.
  - Address and DataOut are held stable. A 4-bit cycle counter (8-bit in ack mode) starts at 0.
  - ACK_EN=0: the strobe lasts exactly STROBE_LEN cycles. On the edge ending the last cycle, reads capture DataIn into rsp_rdata, err=0.
  - ACK_EN=1: the strobe ends on the first edge where ack=1; reads capture DataIn on that edge, err=0.
  - ACK_EN=1 timeout: if ack is not seen by the edge ending strobe cycle TIMEOUT, the strobe ends, rdata=0, err=1, and err_count increments, saturating at 255.
  - ack is ignored outside STROBE.
- State HOLD (1 cycle): strobes 0, Address and DataOut still held (hold time for slaves).
- State RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stable until an edge with rsp_ready=1, then the state returns to IDLE.
  - rsp_ready low holds the block indefinitely; no new command is accepted (cmd_ready=0).
- Latency:
  - Acceptance edge E0. Strobe high from E1 to E(1+n), where n = STROBE_LEN or the ack cycle count.
  - rsp_valid rises after E(2+n).
  - With rsp_ready tied 1, the next command can be accepted on the edge immediately after the response edge.
  - Minimum command period is n+4 clocks.
- Write responses: rsp_rdata=0; rsp_err set only on timeout.

Test Plan:
- ACK_EN=0, STROBE_LEN=2, write addr 0x05 data 0x0000F000 -> Write high for exactly 2 clocks with Address=0x05 and DataOut=0x0000F000 stable from SETUP through HOLD; rsp_valid 4 edges after acceptance, rdata=0, err=0.
- Read addr 0x04 with the slave model returning 0xFFFFFFFF while Read is high -> Read high 2 clocks, Write never high, rsp_rdata=0xFFFFFFFF; Address=0 and DataOut=0 back in IDLE.
- ACK_EN=1, slave acks on the 3rd strobe cycle with DataIn=0x0F000000 -> strobe width 3, rsp_rdata=0x0F000000, err=0, err_count=0.
- ACK_EN=1, TIMEOUT=16, no ack -> strobe width exactly 16, rsp_err=1, rdata=0, err_count=1. After 256 timeouts, err_count stays at 255.
- rsp_ready held 0 for 10 cycles with a second cmd_valid pending -> rsp_valid and data stable, cmd_ready=0 throughout; the second command is accepted on the edge after the rsp_ready=1 handshake.
- rst pulsed during the 2nd strobe cycle -> Read/Write fall without waiting for a clock edge, rsp_valid stays 0, and after release the next command completes normally.

Source files
------------

// File: rtl/lbus_if.sv
`default_nettype none
// ============================================================================
// Module      : lbus_if
// Description : Host command/response channel plus shared local-bus signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface lbus_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  Address;
  logic [31:0] DataOut;
  logic [31:0] DataIn;
  logic        Read;
  logic        Write;
  logic        ack;
  logic [7:0]  err_count;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, DataIn, ack,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, Address, DataOut,
           Read, Write, err_count
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, DataIn, ack,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, Address, DataOut,
           Read, Write, err_count
  );
endinterface
`default_nettype wire

// File: rtl/lbus_master.sv
`default_nettype none
// ============================================================================
// Module      : lbus_master
// Description : Single-outstanding local-bus initiator (SETUP/STROBE/HOLD/RESP).
// Revision    : 1.0 - initial release
// ============================================================================
module lbus_master #(
  parameter int STROBE_LEN = 2,
  parameter int ACK_EN     = 0,
  parameter int TIMEOUT    = 16
) (
  input logic    clk,
  input logic    rst,
  lbus_if.master bus
);
  localparam int c_CW       = (ACK_EN != 0) ? 8 : 4;
  localparam int c_LAST_INT = ((ACK_EN != 0) ? TIMEOUT : STROBE_LEN) - 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_LAST_INT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_write;
  logic [7:0]       r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic [c_CW-1:0]  r_cnt;
  logic [7:0]       r_err_count;
  logic             w_strobe_end;
  logic             w_timeout;

  // Strobe termination: ack wins over a timeout landing on the same edge
  always_comb begin
    w_strobe_end = 1'b0;
    w_timeout    = 1'b0;
    if (r_state == S_STROBE) begin
      if (ACK_EN != 0) begin
        if (bus.ack) begin
          w_strobe_end = 1'b1;
        end else if (r_cnt == c_LAST) begin
          w_strobe_end = 1'b1;
          w_timeout    = 1'b1;
        end
      end else if (r_cnt == c_LAST) begin
        w_strobe_end = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.Read      = 1'b0;
    bus.Write     = 1'b0;
    bus.Address   = 8'h00;
    bus.DataOut   = 32'h0;
    case (r_state)
      S_IDLE: begin
        bus.cmd_ready = ~rst;
        if (bus.cmd_valid) w_next = S_SETUP;
      end
      S_SETUP: begin
        bus.Address = r_addr;
        bus.DataOut = r_wdata;
        w_next      = S_STROBE;
      end
      S_STROBE: begin
        bus.Address = r_addr;
        bus.DataOut = r_wdata;
        bus.Read    = ~r_write;
        bus.Write   = r_write;
        if (w_strobe_end) w_next = S_HOLD;
      end
      S_HOLD: begin
        bus.Address = r_addr;
        bus.DataOut = r_wdata;
        w_next      = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write     <= 1'b0;
      r_addr      <= 8'h00;
      r_wdata     <= 32'h0;
      r_rdata     <= 32'h0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_err_count <= 8'h00;
    end else begin
      if (r_state == S_IDLE && bus.cmd_valid) begin
        r_write <= bus.cmd_write;
        r_addr  <= bus.cmd_addr;
        // Reads put zero on the write-data bus for their whole cycle
        r_wdata <= bus.cmd_write ? bus.cmd_wdata : 32'h0;
      end
      if (r_state == S_SETUP) begin
        r_cnt <= '0;
      end else if (r_state == S_STROBE) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_strobe_end) begin
        r_rdata <= (!r_write && !w_timeout) ? bus.DataIn : 32'h0;
        r_err   <= w_timeout;
        if (w_timeout && r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end
    end
  end

  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign bus.err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_lbus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_lbus_master
// Description : Two DUTs (fixed strobe / ack mode) against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lbus_master;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ec [2];

  logic        cv [2];
  logic        cw [2];
  logic        rr [2];
  logic        ackv [2];
  logic [7:0]  ca [2];
  logic [31:0] cwd [2];
  logic [31:0] din [2];
  logic        cr [2];
  logic        rv [2];
  logic        re [2];
  logic        rs [2];
  logic        ws [2];
  logic [31:0] rd [2];
  logic [31:0] dout [2];
  logic [7:0]  ad [2];
  logic [7:0]  ec [2];

  // Instance 0: fixed 2-clock strobe. Instance 1: ack mode, timeout 16.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    lbus_if bus ();
    assign bus.cmd_valid = cv[g];
    assign bus.cmd_write = cw[g];
    assign bus.cmd_addr  = ca[g];
    assign bus.cmd_wdata = cwd[g];
    assign bus.rsp_ready = rr[g];
    assign bus.DataIn    = din[g];
    assign bus.ack       = ackv[g];
    assign cr[g]   = bus.cmd_ready;
    assign rv[g]   = bus.rsp_valid;
    assign rd[g]   = bus.rsp_rdata;
    assign re[g]   = bus.rsp_err;
    assign ad[g]   = bus.Address;
    assign dout[g] = bus.DataOut;
    assign rs[g]   = bus.Read;
    assign ws[g]   = bus.Write;
    assign ec[g]   = bus.err_count;
    lbus_master #(.STROBE_LEN(2), .ACK_EN(g), .TIMEOUT(16)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
    );
  end

  // One complete command as seen from the host and the slave side
  task automatic txn(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                     input int ack_at, input logic [31:0] rdval, input int rwait,
                     input bit skip_issue, input bit pend, input logic [7:0] pa,
                     input logic [31:0] pwd);
    int n, cyc, width, bad_addr, bad_data, both, wrong;
    bit terr;
    logic [31:0] exp_rd;
    terr   = (d == 1) && !(ack_at >= 1 && ack_at <= 16);
    n      = (d == 0) ? 2 : (terr ? 16 : ack_at);
    exp_rd = (!wr && !terr) ? rdval : 32'h0;
    if (terr) exp_ec[d] = (exp_ec[d] < 255) ? exp_ec[d] + 1 : 255;
    if (!skip_issue) begin
      n_checks++;
      if (cr[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_ready dut%0d: got %b want 1", d, cr[d]);
      end
      cv[d] = 1'b1; cw[d] = wr; ca[d] = a; cwd[d] = wd;
      @(negedge clk);
      cv[d] = 1'b0; cw[d] = 1'b0; ca[d] = 8'h00; cwd[d] = 32'h0;
    end
    cyc = 0; width = 0; bad_addr = 0; bad_data = 0; both = 0; wrong = 0;
    while (rv[d] !== 1'b1 && cyc < 60) begin
      if (ad[d] !== a) bad_addr++;
      if (dout[d] !== (wr ? wd : 32'h0)) bad_data++;
      if (rs[d] === 1'b1 && ws[d] === 1'b1) both++;
      if ((wr ? ws[d] : rs[d]) === 1'b1) begin
        width++;
        if ((wr ? rs[d] : ws[d]) !== 1'b0) wrong++;
        din[d]  = wr ? 32'h0 : rdval;
        ackv[d] = (d == 1) ? (width == ack_at) : 1'($urandom_range(0, 1));
      end else begin
        if (rs[d] !== 1'b0 || ws[d] !== 1'b0) wrong++;
        din[d]  = 32'h0;
        ackv[d] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    din[d] = 32'h0; ackv[d] = 1'b0;
    n_checks++;
    if (cyc !== n + 2) begin
      n_fail++;
      $display("FAIL rsp_latency dut%0d: got %0d edges want %0d", d, cyc, n + 2);
    end
    n_checks++;
    if (width !== n) begin
      n_fail++;
      $display("FAIL strobe_width dut%0d: got %0d want %0d", d, width, n);
    end
    n_checks++;
    if (bad_addr != 0 || bad_data != 0) begin
      n_fail++;
      $display("FAIL bus_stable dut%0d: addr_bad=%0d data_bad=%0d want 0/0", d, bad_addr, bad_data);
    end
    n_checks++;
    if (both != 0 || wrong != 0) begin
      n_fail++;
      $display("FAIL strobe_excl dut%0d: both=%0d wrong=%0d want 0/0", d, both, wrong);
    end
    n_checks++;
    if (rd[d] !== exp_rd || re[d] !== terr) begin
      n_fail++;
      $display("FAIL rsp_data dut%0d: got %h/%b want %h/%b", d, rd[d], re[d], exp_rd, terr);
    end
    n_checks++;
    if (ec[d] !== 8'(exp_ec[d])) begin
      n_fail++;
      $display("FAIL err_count dut%0d: got %0d want %0d", d, ec[d], exp_ec[d]);
    end
    for (int i = 0; i < rwait; i++) begin
      if (pend) begin cv[d] = 1'b1; cw[d] = 1'b1; ca[d] = pa; cwd[d] = pwd; end
      @(negedge clk);
      n_checks++;
      if (rv[d] !== 1'b1 || rd[d] !== exp_rd || re[d] !== terr || cr[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL resp_hold dut%0d: got v=%b d=%h e=%b rdy=%b want 1/%h/%b/0",
                 d, rv[d], rd[d], re[d], cr[d], exp_rd, terr);
      end
    end
    if (pend) begin cv[d] = 1'b1; cw[d] = 1'b1; ca[d] = pa; cwd[d] = pwd; end
    rr[d] = 1'b1;
    @(negedge clk);
    rr[d] = 1'b0;
    n_checks++;
    if (rv[d] !== 1'b0 || cr[d] !== 1'b1 || ad[d] !== 8'h00 || dout[d] !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_after dut%0d: got v=%b rdy=%b a=%h do=%h want 0/1/00/0",
               d, rv[d], cr[d], ad[d], dout[d]);
    end
    if (pend) begin
      @(negedge clk);
      cv[d] = 1'b0; cw[d] = 1'b0; ca[d] = 8'h00; cwd[d] = 32'h0;
      n_checks++;
      if (cr[d] !== 1'b0 || ad[d] !== pa) begin
        n_fail++;
        $display("FAIL pend_accept dut%0d: got rdy=%b a=%h want 0/%h", d, cr[d], ad[d], pa);
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (cr[d] !== 1'b1 || rv[d] !== 1'b0 || rs[d] !== 1'b0 || ws[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl dut%0d: got rdy=%b v=%b r=%b w=%b want 1/0/0/0",
                 d, cr[d], rv[d], rs[d], ws[d]);
      end
      n_checks++;
      if (ad[d] !== 8'h00 || dout[d] !== 32'h0 || rd[d] !== 32'h0 || re[d] !== 1'b0 ||
          ec[d] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_data dut%0d: got a=%h do=%h rd=%h e=%b ec=%0d want zeros",
                 d, ad[d], dout[d], rd[d], re[d], ec[d]);
      end
    end
  endtask

  task automatic test_write();
    txn(0, 1'b1, 8'h05, 32'h0000F000, 0, 32'h0, 0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic test_read();
    txn(0, 1'b0, 8'h04, 32'h0, 0, 32'hFFFFFFFF, 0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic test_ack();
    txn(1, 1'b0, 8'h10, 32'h0, 3, 32'h0F000000, 0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic test_timeout();
    txn(1, 1'b0, 8'h11, 32'h0, 0, 32'hDEADBEEF, 1, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic test_backpressure();
    txn(0, 1'b0, 8'h04, 32'h0, 0, 32'h12345678, 10, 1'b0, 1'b1, 8'h21, 32'hCAFE0001);
    txn(0, 1'b1, 8'h21, 32'hCAFE0001, 0, 32'h0, 0, 1'b1, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
          32'($urandom), int'($urandom_range(0, 18)), 32'($urandom),
          int'($urandom_range(0, 3)), 1'b0, 1'b0, 8'h00, 32'h0);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 256; i++) begin
      txn(1, 1'b1, 8'h7F, 32'($urandom), 0, 32'h0, 0, 1'b0, 1'b0, 8'h00, 32'h0);
    end
    n_checks++;
    if (ec[1] !== 8'd255) begin
      n_fail++;
      $display("FAIL err_saturate: got %0d want 255", ec[1]);
    end
  endtask

  task automatic test_reset_mid();
    cv[0] = 1'b1; cw[0] = 1'b0; ca[0] = 8'h33; cwd[0] = 32'h0;
    @(negedge clk);
    cv[0] = 1'b0; ca[0] = 8'h00;
    din[0] = 32'hA5A5A5A5;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (rs[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre_strobe: got %b want 1", rs[0]);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (rs[0] !== 1'b0 || ws[0] !== 1'b0 || rv[0] !== 1'b0 || ec[1] !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_async_drop: got r=%b w=%b v=%b ec1=%0d want 0/0/0/0",
               rs[0], ws[0], rv[0], ec[1]);
    end
    #1 rst = 1'b0;
    din[0] = 32'h0;
    exp_ec[0] = 0;
    exp_ec[1] = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (rv[0] !== 1'b0 || cr[0] !== 1'b1 || rs[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_no_resp: got v=%b rdy=%b r=%b want 0/1/0", rv[0], cr[0], rs[0]);
      end
    end
    txn(0, 1'b0, 8'h34, 32'h0, 0, 32'h5555AAAA, 0, 1'b0, 1'b0, 8'h00, 32'h0);
    txn(1, 1'b0, 8'h35, 32'h0, 0, 32'h0, 0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cv[d] = 1'b0; cw[d] = 1'b0; ca[d] = 8'h00; cwd[d] = 32'h0;
      rr[d] = 1'b0; din[d] = 32'h0; ackv[d] = 1'b0; exp_ec[d] = 0;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (cr[0] !== 1'b0 || cr[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_in_reset: got %b/%b want 0/0", cr[0], cr[1]);
    end
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_ack();
    test_timeout();
    test_backpressure();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
